// File: rtl/finite_state_machine_pkg.sv
// rtl/finite_state_machine_pkg.sv - shared opcodes, state type and widths for the SPI sequencer FSM
package finite_state_machine_pkg;

  localparam int INSTR_W = 10;
  localparam int DATA_W  = 8;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_CMD  = 2'b01;
  localparam logic [1:0] OP_DATA = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

endpackage

// File: rtl/finite_state_machine.sv
// rtl/finite_state_machine.sv - instruction-driven SPI byte sequencer with chip select and PC advance
module finite_state_machine
  import finite_state_machine_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              sclkPosEdge,
  input  logic [INSTR_W-1:0] instr,
  output logic              cs,
  output logic              dc,
  output logic              pcEn,
  output logic [DATA_W-1:0] parallelData
);

  state_t     state;
  logic [2:0] bit_cnt;

  // Sequencer: steps only on serial-clock rising edges; pcEn is a one-clk pulse cleared every edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= 3'd0;
      cs           <= 1'b1;
      dc           <= 1'b0;
      pcEn         <= 1'b0;
      parallelData <= '0;
    end else begin
      pcEn <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sclkPosEdge) begin
            case (instr[9:8])
              OP_NOP: begin
                pcEn <= 1'b1;
                cs   <= 1'b1;
              end
              OP_CMD, OP_DATA: begin
                parallelData <= instr[7:0];
                dc           <= instr[9];
                cs           <= 1'b0;
                bit_cnt      <= 3'd0;
                state        <= ST_SHIFT;
              end
              default: begin
                cs    <= 1'b1;
                state <= ST_HALT;
              end
            endcase
          end
        end
        ST_SHIFT: begin
          if (sclkPosEdge) begin
            // counter wraps 7 -> 0 on the same step that ends the byte
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              pcEn  <= 1'b1;
              cs    <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        ST_HALT: begin
          cs <= 1'b1;
        end
        default: begin
          // unreachable encodings recover immediately, independent of the step strobe
          state   <= ST_IDLE;
          bit_cnt <= 3'd0;
          cs      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_finite_state_machine.sv
// tb/tb_finite_state_machine.sv - randomized and directed checks of finite_state_machine against a behavioural model
module tb_finite_state_machine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk_pos_edge = 1'b0;
  logic [9:0] instr = 10'h000;
  logic       cs, dc, pc_en;
  logic [7:0] parallel_data;

  int checks = 0;
  int passes = 0;

  // model state: bytes-in-flight expressed as steps remaining, plus a halt flag
  int         m_left = 0;
  bit         m_halt = 1'b0;
  logic       m_cs = 1'b1, m_dc = 1'b0, m_pc = 1'b0;
  logic [7:0] m_pd = 8'h00;

  finite_state_machine dut (
    .clk          (clk),
    .reset        (reset),
    .sclkPosEdge  (sclk_pos_edge),
    .instr        (instr),
    .cs           (cs),
    .dc           (dc),
    .pcEn         (pc_en),
    .parallelData (parallel_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // behavioural reference: one serial step per strobe, byte lasts 8 steps after the sampling step
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0; m_halt = 1'b0;
      m_cs = 1'b1; m_dc = 1'b0; m_pc = 1'b0; m_pd = 8'h00;
    end else begin
      m_pc = 1'b0;
      if (sclk_pos_edge && !m_halt) begin
        if (m_left > 0) begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_pc = 1'b1; m_cs = 1'b1; end
        end else begin
          case (instr[9:8])
            2'd0: m_pc = 1'b1;
            2'd1, 2'd2: begin
              m_pd = instr[7:0];
              m_dc = (instr[9:8] == 2'd2);
              m_cs = 1'b0;
              m_left = 8;
            end
            default: m_halt = 1'b1;
          endcase
        end
      end
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("cs", int'(cs), int'(m_cs));
    check("dc", int'(dc), int'(m_dc));
    check("pcEn", int'(pc_en), int'(m_pc));
    check("parallelData", int'(parallel_data), int'(m_pd));
  end

  task automatic tick(input logic [9:0] i, input logic s);
    instr = i;
    sclk_pos_edge = s;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(instr, 1'b0);
    reset = 1'b0;
  endtask

  int pulses, cs_low, pc_cycles;

  initial begin
    @(posedge clk); #2;
    tick(10'h000, 1'b0);
    check("reset_cs", int'(cs), 1);
    check("reset_pc", int'(pc_en), 0);
    check("reset_pd", int'(parallel_data), 0);
    reset = 1'b0;

    // COMMAND 0x1AE with sclk every clk
    tick(10'h1AE, 1'b1);
    check("cmd_cs", int'(cs), 0);
    check("cmd_dc", int'(dc), 0);
    check("cmd_pd", int'(parallel_data), 8'hAE);
    pulses = 0; cs_low = 0;
    for (int k = 0; k < 8; k++) begin
      tick(10'($urandom), 1'b1);
      if (pc_en) pulses++;
      if (!cs) cs_low++;
    end
    check("cmd_pulses", pulses, 1);
    check("cmd_pc_last", int'(pc_en), 1);
    check("cmd_cs_low", cs_low, 7);
    tick(10'h1AE, 1'b0);
    check("cmd_pc_clear", int'(pc_en), 0);
    check("cmd_cs_end", int'(cs), 1);

    // DATA 0x2FF with sclk every other clk
    tick(10'h2FF, 1'b1);
    check("data_dc", int'(dc), 1);
    check("data_pd", int'(parallel_data), 8'hFF);
    pulses = 0; cs_low = 1;
    for (int k = 0; k < 8; k++) begin
      tick(10'h155, 1'b0);
      if (pc_en) pulses++;
      tick(10'h155, 1'b1);
      if (pc_en) pulses++;
      if (!cs) cs_low++;
    end
    check("data_pulses", pulses, 1);
    check("data_cs_low", cs_low, 8);

    // quiet period: outputs hold last loaded values
    for (int k = 0; k < 50; k++) tick(10'($urandom), 1'b0);
    check("quiet_cs", int'(cs), 1);
    check("quiet_dc", int'(dc), 1);
    check("quiet_pd", int'(parallel_data), 8'hFF);
    check("quiet_pc", int'(pc_en), 0);

    // NOP for 3 strobes spaced 4 clks apart
    pc_cycles = 0; cs_low = 0;
    for (int k = 0; k < 12; k++) begin
      tick(10'h000, (k % 4) == 0);
      if (pc_en) pc_cycles++;
      if (!cs) cs_low++;
    end
    check("nop_pc_cycles", pc_cycles, 3);
    check("nop_cs_low", cs_low, 0);

    // reset mid-shift
    tick(10'h155, 1'b1);
    tick(10'h000, 1'b1);
    tick(10'h000, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_cs", int'(cs), 1);
    check("rst_dc", int'(dc), 0);
    check("rst_pc", int'(pc_en), 0);
    check("rst_pd", int'(parallel_data), 0);
    tick(10'h155, 1'b0);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick(10'h155, 1'b0);
      if (pc_en) pulses++;
    end
    check("rst_no_pc", pulses, 0);

    // HALT with changing instr
    tick(10'h3A5, 1'b1);
    pulses = 0; cs_low = 0;
    for (int k = 0; k < 20; k++) begin
      tick(10'($urandom), 1'b1);
      if (pc_en) pulses++;
      if (!cs) cs_low++;
    end
    check("halt_pc", pulses, 0);
    check("halt_cs_low", cs_low, 0);
    do_reset();

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      logic [9:0] r;
      r = 10'($urandom);
      if (r[9:8] == 2'b11 && $urandom_range(0, 19) != 0) r[9] = 1'b0;
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        tick(r, 1'($urandom));
        reset = 1'b0;
      end else begin
        tick(r, ($urandom_range(0, 2) != 0));
      end
    end

    @(posedge clk); #2;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
